// File: rtl/rvfi_cover_stats_if.sv
// RVFI retire/rollback bus as seen by the cover-statistics monitor.
// Parameters NRET and ILEN must match the attached monitor.
interface rvfi_cover_stats_if #(
  parameter int NRET = 1,
  parameter int ILEN = 32
);
  // Valid-only bus with no ready: each retire channel and the rollback event count in every cycle where their valid is high. The monitor always accepts.
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*ILEN-1:0] rvfi_insn;
  logic [NRET*64-1:0]   rvfi_order;
  logic [NRET-1:0]      rvfi_trap;
  logic [NRET-1:0]      rvfi_intr;
  logic                 rvfi_rollback_valid;
  logic [63:0]          rvfi_rollback_order;

  modport master (
    output rvfi_valid, rvfi_insn, rvfi_order, rvfi_trap, rvfi_intr,
    output rvfi_rollback_valid, rvfi_rollback_order
  );

  modport slave (
    input rvfi_valid, rvfi_insn, rvfi_order, rvfi_trap, rvfi_intr,
    input rvfi_rollback_valid, rvfi_rollback_order
  );
endinterface

// File: rtl/rvfi_cover_stats.sv
// Registered RVFI cover-statistics monitor: saturating retire counters, rollback phase FSM, order-gap and threshold flags.
// Define RISCV_FORMAL_COVER_HIST_EN to add the retire-width histogram and the compressed-instruction counter.
module rvfi_cover_stats #(
  parameter int NRET   = 1,
  parameter int ILEN   = 32,
  parameter int CW     = 16,
  parameter int TARGET = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       check,
  rvfi_cover_stats_if.slave          rvfi,
  output logic [NRET*CW-1:0]         chan_cnt_insns,
  output logic [CW-1:0]              cnt_insns,
  output logic [CW-1:0]              cnt_trap,
  output logic [CW-1:0]              cnt_intr,
  output logic [CW-1:0]              cnt_norm,
  output logic [CW-1:0]              arb_cnt_insns,
  output logic [CW-1:0]              cnt_rollback,
  output logic [$clog2(NRET+1)-1:0]  max_ret,
  output logic [1:0]                 phase,
  output logic                       order_gap,
  output logic [3:0]                 hit_mask
`ifdef RISCV_FORMAL_COVER_HIST_EN
  ,
  output logic [(NRET+1)*CW-1:0]     ret_hist,
  output logic [CW-1:0]              cnt_compressed
`endif
);
  localparam int VW = $clog2(NRET+1);
  localparam int AW = CW + VW;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] TGT  = CW'(TARGET);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ROLLBACK = 2'd2, RECOVER = 2'd3} phase_e;

  // Widen before adding so the clamp sees the true sum.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cur, input logic [VW-1:0] inc);
    logic [AW-1:0] sum;
    sum = AW'(cur) + AW'(inc);
    return (sum > AW'(CMAX)) ? CMAX : sum[CW-1:0];
  endfunction

  phase_e              phase_q, phase_d;
  logic [NRET*CW-1:0]  chan_q, chan_d;
  logic [CW-1:0]       ins_q, ins_d, trap_q, trap_d, intr_q, intr_d, norm_q, norm_d;
  logic [CW-1:0]       arb_q, arb_d, rb_q, rb_d;
  logic [VW-1:0]       max_q, max_d;
  logic [63:0]         exp_order_q, exp_order_d;
  logic                gap_q, gap_d;
  logic [3:0]          hit_q, hit_d;
  logic [VW-1:0]       v, t, i, n;
  logic [63:0]         base, want;
  logic                seen, mismatch;

  always_comb begin
    v = '0;
    t = '0;
    i = '0;
    n = '0;
    chan_d = chan_q;
    for (int c = 0; c < NRET; c++) begin
      chan_d[c*CW +: CW] = sat_add(chan_q[c*CW +: CW], VW'(rvfi.rvfi_valid[c]));
      if (rvfi.rvfi_valid[c]) begin
        v = v + VW'(1);
        if (rvfi.rvfi_trap[c]) t = t + VW'(1);
        if (rvfi.rvfi_intr[c]) i = i + VW'(1);
        if (!rvfi.rvfi_trap[c] && !rvfi.rvfi_intr[c]) n = n + VW'(1);
      end
    end
    ins_d  = sat_add(ins_q, v);
    trap_d = sat_add(trap_q, t);
    intr_d = sat_add(intr_q, i);
    norm_d = sat_add(norm_q, n);
    // Same-cycle retirements belong to the pre-rollback epoch: judge by the registered phase.
    arb_d  = (phase_q == ROLLBACK || phase_q == RECOVER) ? sat_add(arb_q, v) : arb_q;
    rb_d   = sat_add(rb_q, VW'(rvfi.rvfi_rollback_valid));
    max_d  = (v > max_q) ? v : max_q;
    hit_d  = hit_q | {arb_d >= TGT, intr_d >= TGT, trap_d >= TGT, ins_d >= TGT};
  end

  always_comb begin
    phase_d = phase_q;
    if (rvfi.rvfi_rollback_valid) begin
      phase_d = ROLLBACK;
    end else begin
      case (phase_q)
        IDLE:     if (v != '0) phase_d = RUN;
        ROLLBACK: if (v != '0) phase_d = RECOVER;
        default:  phase_d = phase_q;
      endcase
    end
  end

  // Before the first retirement there is no expected order: take it from the lowest valid channel.
  always_comb begin
    base = exp_order_q;
    seen = 1'b0;
    if (phase_q == IDLE) begin
      for (int c = 0; c < NRET; c++) begin
        if (rvfi.rvfi_valid[c] && !seen) begin
          base = rvfi.rvfi_order[c*64 +: 64];
          seen = 1'b1;
        end
      end
    end
    want     = base;
    mismatch = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi.rvfi_valid[c]) begin
        if (rvfi.rvfi_order[c*64 +: 64] != want) mismatch = 1'b1;
        want = want + 64'd1;
      end
    end
    exp_order_d = exp_order_q;
    if (rvfi.rvfi_rollback_valid) exp_order_d = rvfi.rvfi_rollback_order;
    else if (v != '0)             exp_order_d = want;
    gap_d = gap_q | (mismatch & ~rvfi.rvfi_rollback_valid);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q     <= IDLE;
      chan_q      <= '0;
      ins_q       <= '0;
      trap_q      <= '0;
      intr_q      <= '0;
      norm_q      <= '0;
      arb_q       <= '0;
      rb_q        <= '0;
      max_q       <= '0;
      exp_order_q <= '0;
      gap_q       <= 1'b0;
      hit_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      chan_q      <= chan_d;
      ins_q       <= ins_d;
      trap_q      <= trap_d;
      intr_q      <= intr_d;
      norm_q      <= norm_d;
      arb_q       <= arb_d;
      rb_q        <= rb_d;
      max_q       <= max_d;
      exp_order_q <= exp_order_d;
      gap_q       <= gap_d;
      hit_q       <= hit_d;
    end
  end

  assign chan_cnt_insns = chan_q;
  assign cnt_insns      = ins_q;
  assign cnt_trap       = trap_q;
  assign cnt_intr       = intr_q;
  assign cnt_norm       = norm_q;
  assign arb_cnt_insns  = arb_q;
  assign cnt_rollback   = rb_q;
  assign max_ret        = max_q;
  assign phase          = phase_q;
  assign order_gap      = gap_q;
  assign hit_mask       = check ? hit_q : 4'b0000;

`ifdef RISCV_FORMAL_COVER_HIST_EN
  logic [(NRET+1)*CW-1:0] hist_q, hist_d;
  logic [CW-1:0]          comp_q, comp_d;
  logic [VW-1:0]          cc;

  // Bin 0 only counts idle cycles once the core has started retiring.
  always_comb begin
    hist_d = hist_q;
    for (int b = 0; b <= NRET; b++) begin
      if (v == VW'(b) && (b != 0 || phase_q != IDLE))
        hist_d[b*CW +: CW] = sat_add(hist_q[b*CW +: CW], VW'(1));
    end
    cc = '0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi.rvfi_valid[c] && rvfi.rvfi_insn[c*ILEN +: 2] != 2'b11) cc = cc + VW'(1);
    end
    comp_d = sat_add(comp_q, cc);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '0;
      comp_q <= '0;
    end else begin
      hist_q <= hist_d;
      comp_q <= comp_d;
    end
  end

  assign ret_hist       = hist_q;
  assign cnt_compressed = comp_q;
`endif
endmodule

// File: tb/tb_rvfi_cover_stats.sv
// Scoreboard bench for rvfi_cover_stats (NRET=2, CW=4, TARGET=8): a reference model pushes expected outputs per driven cycle.
module tb_rvfi_cover_stats;
  localparam int NRET = 2, ILEN = 32, CW = 4, TARGET = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic check = 1'b1;
  always #5 clock = ~clock;

  rvfi_cover_stats_if #(.NRET(NRET), .ILEN(ILEN)) bus ();

  logic [NRET*CW-1:0] chan_cnt_insns;
  logic [CW-1:0]      cnt_insns, cnt_trap, cnt_intr, cnt_norm, arb_cnt_insns, cnt_rollback;
  logic [1:0]         max_ret, phase;
  logic               order_gap;
  logic [3:0]         hit_mask;
`ifdef RISCV_FORMAL_COVER_HIST_EN
  logic [(NRET+1)*CW-1:0] ret_hist;
  logic [CW-1:0]          cnt_compressed;
`endif

  rvfi_cover_stats #(.NRET(NRET), .ILEN(ILEN), .CW(CW), .TARGET(TARGET)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .check          (check),
    .rvfi           (bus.slave),
    .chan_cnt_insns (chan_cnt_insns),
    .cnt_insns      (cnt_insns),
    .cnt_trap       (cnt_trap),
    .cnt_intr       (cnt_intr),
    .cnt_norm       (cnt_norm),
    .arb_cnt_insns  (arb_cnt_insns),
    .cnt_rollback   (cnt_rollback),
    .max_ret        (max_ret),
    .phase          (phase),
    .order_gap      (order_gap),
    .hit_mask       (hit_mask)
`ifdef RISCV_FORMAL_COVER_HIST_EN
    ,
    .ret_hist       (ret_hist),
    .cnt_compressed (cnt_compressed)
`endif
  );

  typedef struct packed {
    logic [3:0] ch1, ch0, ins, trap, intr, norm, arb, rb;
    logic [1:0] mx, ph;
    logic       gap;
    logic [3:0] hit;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int m_chan[2], m_ins, m_trap, m_intr, m_norm, m_arb, m_rb, m_max, m_phase, m_gap, m_hit[4];
  longint unsigned m_exp;

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_reset();
    m_chan[0] = 0; m_chan[1] = 0;
    m_ins = 0; m_trap = 0; m_intr = 0; m_norm = 0; m_arb = 0; m_rb = 0;
    m_max = 0; m_phase = 0; m_gap = 0; m_exp = 0;
    for (int b = 0; b < 4; b++) m_hit[b] = 0;
  endtask

  task automatic model_step(input logic [1:0] valid, input longint unsigned o0, input longint unsigned o1,
                            input logic [1:0] trap, input logic [1:0] intr, input logic rb,
                            input longint unsigned rbo);
    int v, t, ii, n, k;
    longint unsigned ord[2];
    longint unsigned base;
    exp_t e;
    v = 0; t = 0; ii = 0; n = 0;
    ord[0] = o0; ord[1] = o1;
    for (int c = 0; c < 2; c++) begin
      if (valid[c]) begin
        v++;
        m_chan[c] = sat(m_chan[c] + 1);
        if (trap[c]) t++;
        if (intr[c]) ii++;
        if (!trap[c] && !intr[c]) n++;
      end
    end
    m_ins = sat(m_ins + v); m_trap = sat(m_trap + t); m_intr = sat(m_intr + ii); m_norm = sat(m_norm + n);
    if (m_phase == 2 || m_phase == 3) m_arb = sat(m_arb + v);
    if (rb) m_rb = sat(m_rb + 1);
    if (v > m_max) m_max = v;
    if (rb) begin
      m_exp = rbo;
    end else if (v > 0) begin
      base = m_exp;
      if (m_phase == 0) base = valid[0] ? o0 : o1;
      k = 0;
      for (int c = 0; c < 2; c++) begin
        if (valid[c]) begin
          if (ord[c] != base + longint'(k)) m_gap = 1;
          k++;
        end
      end
      m_exp = base + longint'(v);
    end
    if (rb) m_phase = 2;
    else if (m_phase == 0 && v > 0) m_phase = 1;
    else if (m_phase == 2 && v > 0) m_phase = 3;
    if (m_ins >= TARGET) m_hit[0] = 1;
    if (m_trap >= TARGET) m_hit[1] = 1;
    if (m_intr >= TARGET) m_hit[2] = 1;
    if (m_arb >= TARGET) m_hit[3] = 1;
    e.ch1 = 4'(m_chan[1]); e.ch0 = 4'(m_chan[0]);
    e.ins = 4'(m_ins); e.trap = 4'(m_trap); e.intr = 4'(m_intr); e.norm = 4'(m_norm);
    e.arb = 4'(m_arb); e.rb = 4'(m_rb); e.mx = 2'(m_max); e.ph = 2'(m_phase); e.gap = 1'(m_gap);
    e.hit = {1'(m_hit[3]), 1'(m_hit[2]), 1'(m_hit[1]), 1'(m_hit[0])};
    exp_q.push_back(EW'(e));
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    chk("chan0", 64'(chan_cnt_insns[3:0]), 64'(e.ch0));
    chk("chan1", 64'(chan_cnt_insns[7:4]), 64'(e.ch1));
    chk("cnt_insns", 64'(cnt_insns), 64'(e.ins));
    chk("cnt_trap", 64'(cnt_trap), 64'(e.trap));
    chk("cnt_intr", 64'(cnt_intr), 64'(e.intr));
    chk("cnt_norm", 64'(cnt_norm), 64'(e.norm));
    chk("arb_cnt", 64'(arb_cnt_insns), 64'(e.arb));
    chk("cnt_rollback", 64'(cnt_rollback), 64'(e.rb));
    chk("max_ret", 64'(max_ret), 64'(e.mx));
    chk("phase", 64'(phase), 64'(e.ph));
    chk("order_gap", 64'(order_gap), 64'(e.gap));
    chk("hit_mask", 64'(hit_mask), 64'(e.hit));
  endtask

  task automatic drive(input logic [1:0] valid, input longint unsigned o0, input longint unsigned o1,
                       input logic [1:0] trap, input logic [1:0] intr, input logic rb,
                       input longint unsigned rbo);
    @(negedge clock);
    bus.rvfi_valid          = valid;
    bus.rvfi_order          = {o1[63:0], o0[63:0]};
    bus.rvfi_trap           = trap;
    bus.rvfi_intr           = intr;
    bus.rvfi_insn           = {$urandom, $urandom};
    bus.rvfi_rollback_valid = rb;
    bus.rvfi_rollback_order = rbo;
    model_step(valid, o0, o1, trap, intr, rb, rbo);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_chan"}, 64'(chan_cnt_insns), 64'd0);
    chk({pfx, "_ins"}, 64'(cnt_insns), 64'd0);
    chk({pfx, "_trap"}, 64'(cnt_trap), 64'd0);
    chk({pfx, "_intr"}, 64'(cnt_intr), 64'd0);
    chk({pfx, "_norm"}, 64'(cnt_norm), 64'd0);
    chk({pfx, "_arb"}, 64'(arb_cnt_insns), 64'd0);
    chk({pfx, "_rb"}, 64'(cnt_rollback), 64'd0);
    chk({pfx, "_max"}, 64'(max_ret), 64'd0);
    chk({pfx, "_phase"}, 64'(phase), 64'd0);
    chk({pfx, "_gap"}, 64'(order_gap), 64'd0);
    chk({pfx, "_hit"}, 64'(hit_mask), 64'd0);
`ifdef RISCV_FORMAL_COVER_HIST_EN
    chk({pfx, "_hist"}, 64'(ret_hist), 64'd0);
    chk({pfx, "_comp"}, 64'(cnt_compressed), 64'd0);
`endif
  endtask

  task automatic idle_bus();
    bus.rvfi_valid = '0; bus.rvfi_order = '0; bus.rvfi_trap = '0; bus.rvfi_intr = '0;
    bus.rvfi_insn = '0; bus.rvfi_rollback_valid = 1'b0; bus.rvfi_rollback_order = '0;
  endtask

  // Asserts reset between edges and checks the outputs clear before the next rising edge.
  task automatic do_reset(input string pfx);
    @(negedge clock);
    idle_bus();
    #2 resetn = 1'b0;
    #1 chk_zero(pfx);
    model_reset();
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  longint unsigned nxt;
  logic [1:0] rv, rt, ri;
  logic rrb;
  longint unsigned rbo, o0, o1;
  int ph_exp[6];

  initial begin
    idle_bus();
    model_reset();
    #7 chk_zero("por");
    @(negedge clock);
    resetn = 1'b1;

    // Saturation at CW=4
    nxt = 0;
    for (int c = 0; c < 3; c++) begin drive(2'b11, nxt, nxt + 1, 2'b00, 2'b00, 1'b0, 0); nxt += 2; end
    for (int c = 0; c < 6; c++) begin drive(2'b01, nxt, 0, 2'b00, 2'b00, 1'b0, 0); nxt += 1; end
    chk("sat_cnt12", 64'(cnt_insns), 64'd12);
    for (int c = 0; c < 3; c++) begin drive(2'b01, nxt, 0, 2'b00, 2'b00, 1'b0, 0); nxt += 1; end
    chk("sat_cnt15", 64'(cnt_insns), 64'd15);
    drive(2'b11, nxt, nxt + 1, 2'b00, 2'b00, 1'b0, 0);
    chk("sat_stay15", 64'(cnt_insns), 64'd15);
    chk("sat_max_ret", 64'(max_ret), 64'd2);
    chk("sat_hit0", 64'(hit_mask[0]), 64'd1);
    check = 1'b0;
    #1 chk("hit_gated", 64'(hit_mask), 64'd0);
    check = 1'b1;
    #1 chk("hit_ungated", 64'(hit_mask[0]), 64'd1);

    // Rollback phase sequence on channel 0
    do_reset("rst_a");
    ph_exp = '{1, 1, 1, 2, 3, 3};
    drive(2'b01, 0, 0, 2'b00, 2'b00, 1'b0, 0); chk("rb_ph0", 64'(phase), 64'(ph_exp[0]));
    drive(2'b01, 1, 0, 2'b00, 2'b00, 1'b0, 0); chk("rb_ph1", 64'(phase), 64'(ph_exp[1]));
    drive(2'b01, 2, 0, 2'b00, 2'b00, 1'b0, 0); chk("rb_ph2", 64'(phase), 64'(ph_exp[2]));
    drive(2'b00, 0, 0, 2'b00, 2'b00, 1'b1, 1); chk("rb_ph3", 64'(phase), 64'(ph_exp[3]));
    drive(2'b01, 1, 0, 2'b00, 2'b00, 1'b0, 0); chk("rb_ph4", 64'(phase), 64'(ph_exp[4]));
    drive(2'b01, 2, 0, 2'b00, 2'b00, 1'b0, 0); chk("rb_ph5", 64'(phase), 64'(ph_exp[5]));
    chk("rb_arb2", 64'(arb_cnt_insns), 64'd2);
    chk("rb_count1", 64'(cnt_rollback), 64'd1);
    chk("rb_nogap", 64'(order_gap), 64'd0);

    // Order gap is sticky
    do_reset("rst_b");
    drive(2'b11, 5, 6, 2'b00, 2'b00, 1'b0, 0);  chk("gap_first", 64'(order_gap), 64'd0);
    drive(2'b11, 7, 9, 2'b00, 2'b00, 1'b0, 0);  chk("gap_set", 64'(order_gap), 64'd1);
    drive(2'b11, 10, 11, 2'b00, 2'b00, 1'b0, 0); chk("gap_sticky", 64'(order_gap), 64'd1);

    // Rollback with a same-cycle retirement from RUN
    do_reset("rst_c");
    drive(2'b01, 0, 0, 2'b00, 2'b00, 1'b0, 0);
    drive(2'b01, 1, 0, 2'b00, 2'b00, 1'b1, 0);
    chk("rbv_ins", 64'(cnt_insns), 64'd2);
    chk("rbv_arb", 64'(arb_cnt_insns), 64'd0);
    chk("rbv_phase", 64'(phase), 64'd2);

    // Trap and interrupt on one retirement
    do_reset("rst_d");
    drive(2'b01, 0, 0, 2'b01, 2'b01, 1'b0, 0);
    chk("ti_trap", 64'(cnt_trap), 64'd1);
    chk("ti_intr", 64'(cnt_intr), 64'd1);
    chk("ti_norm", 64'(cnt_norm), 64'd0);
    chk("ti_ins", 64'(cnt_insns), 64'd1);

    // Random traffic with occasional rollbacks and bad orders
    do_reset("rst_e");
    nxt = 64'd100;
    for (int c = 0; c < 60; c++) begin
      rv  = 2'($urandom_range(0, 3));
      rt  = 2'($urandom_range(0, 3));
      ri  = 2'($urandom_range(0, 3));
      rrb = ($urandom_range(0, 7) == 0);
      rbo = longint'($urandom_range(0, 200));
      o0  = nxt;
      o1  = rv[0] ? nxt + 1 : nxt;
      if ($urandom_range(0, 15) == 0) o1 = o1 + 3;
      drive(rv, o0, o1, rt, ri, rrb, rbo);
      if (rrb) nxt = rbo;
      else nxt = nxt + longint'(rv[0]) + longint'(rv[1]);
    end

    // Reset mid-run with counters nonzero
    do_reset("rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
